// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pkg
//  Purpose  : Decode modes and the code-to-pattern decode function.
//  Revision : 1.0  initial release
// ============================================================================
package decoder_pkg;

    localparam logic [1:0] MODE_ONEHOT   = 2'd0;
    localparam logic [1:0] MODE_THERM    = 2'd1;
    localparam logic [1:0] MODE_ONEHOT_N = 2'd2;
    localparam logic [1:0] MODE_RSVD     = 2'd3;

    localparam int c_MAX_IN_W  = 6;
    localparam int c_MAX_OUT_W = 2 ** c_MAX_IN_W;

    // Returns {err, data}; callers keep only the low 2**IN_W data bits.
    function automatic logic [c_MAX_OUT_W:0] decode_f(
        input logic [c_MAX_IN_W-1:0] code,
        input logic [1:0]            mode
    );
        logic [c_MAX_OUT_W-1:0] w_data;
        logic                   w_err;
        w_data = '0;
        w_err  = 1'b0;
        case (mode)
            MODE_ONEHOT:   w_data[code] = 1'b1;
            MODE_THERM: begin
                for (int i = 0; i < c_MAX_OUT_W; i++) begin
                    w_data[i] = (i <= int'(code));
                end
            end
            MODE_ONEHOT_N: begin
                w_data       = '1;
                w_data[code] = 1'b0;
            end
            default:       w_err = 1'b1;
        endcase
        return {w_err, w_data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_slice.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_slice
//  Purpose  : One elastic valid/ready register slice with a W-bit payload.
//  Revision : 1.0  initial release
// ============================================================================
module decoder_slice
    import decoder_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Loads when empty or when the downstream side takes the held beat.
    assign in_ready  = ~r_valid | out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pipe
//  Purpose  : Pipelined code-to-pattern decoder with valid/ready on both sides.
//             Optional DECODER_PARITY_EN adds out_par (XOR of out_data).
//  Revision : 1.0  initial release
// ============================================================================
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int IN_W   = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_W-1:0]      in_code,
    input  logic [1:0]           in_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2**IN_W-1:0]   out_data,
    output logic                 out_err,
`ifdef DECODER_PARITY_EN
    output logic                 out_par,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     xfer_cnt
);

    localparam int OUT_W = 2 ** IN_W;
`ifdef DECODER_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int PW = OUT_W + 1 + PAR_W;

    logic [c_MAX_IN_W-1:0]   w_code;
    logic [c_MAX_OUT_W:0]    w_dec;
    logic [PW-1:0]           w_payload;
    logic [STAGES:0]         w_valid;
    logic [STAGES:0]         w_ready;
    logic [STAGES:0][PW-1:0] w_data;
    logic [CNT_W-1:0]        r_xfer_cnt;

    always_comb begin
        w_code             = '0;
        w_code[IN_W-1:0]   = in_code;
    end

    assign w_dec = decode_f(w_code, in_mode);

    generate
        if (OUT_W < c_MAX_OUT_W) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^w_dec[c_MAX_OUT_W-1:OUT_W];
        end
    endgenerate

`ifdef DECODER_PARITY_EN
    assign w_payload = {^w_dec[OUT_W-1:0], w_dec[c_MAX_OUT_W], w_dec[OUT_W-1:0]};
`else
    assign w_payload = {w_dec[c_MAX_OUT_W], w_dec[OUT_W-1:0]};
`endif

    assign w_valid[0]      = in_valid;
    assign w_data[0]       = w_payload;
    assign in_ready        = w_ready[0];
    assign w_ready[STAGES] = out_ready;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_slice
            decoder_slice #(.W(PW)) u_slice (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (w_valid[k]),
                .in_ready  (w_ready[k]),
                .in_data   (w_data[k]),
                .out_valid (w_valid[k+1]),
                .out_ready (w_ready[k+1]),
                .out_data  (w_data[k+1])
            );
        end
    endgenerate

    assign out_valid = w_valid[STAGES];
    assign out_data  = w_data[STAGES][OUT_W-1:0];
    assign out_err   = w_data[STAGES][OUT_W];
`ifdef DECODER_PARITY_EN
    assign out_par   = w_data[STAGES][OUT_W+1];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_xfer_cnt <= '0;
        end else if (out_valid && out_ready) begin
            r_xfer_cnt <= r_xfer_cnt + 1'b1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_pipe
//  Purpose  : Self-checking bench for decoder_pipe against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decoder_pipe;

    localparam int IN_W   = 4;
    localparam int STAGES = 2;

    logic        clk;
    logic        reset;
    logic [3:0]  in_code;
    logic [1:0]  in_mode;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready,  in_ready4;
    logic [15:0] out_data,  out_data4;
    logic        out_err,   out_err4;
    logic        out_valid, out_valid4;
    logic [15:0] xfer_cnt;
    logic [3:0]  xfer_cnt4;
`ifdef DECODER_PARITY_EN
    logic        out_par, out_par4;
`endif

    decoder_pipe #(.IN_W(IN_W), .STAGES(STAGES), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_code(in_code), .in_mode(in_mode),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_err(out_err),
`ifdef DECODER_PARITY_EN
        .out_par(out_par),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    decoder_pipe #(.IN_W(IN_W), .STAGES(STAGES), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_code(in_code), .in_mode(in_mode),
        .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
        .out_err(out_err4),
`ifdef DECODER_PARITY_EN
        .out_par(out_par4),
`endif
        .out_valid(out_valid4), .out_ready(out_ready), .xfer_cnt(xfer_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference decode straight from the mode rules: returns {err, data}.
    function automatic logic [16:0] ref_decode(input int code, input int mode);
        case (mode)
            0:       return {1'b0, 16'(1 << code)};
            1:       return {1'b0, 16'((1 << (code + 1)) - 1)};
            2:       return {1'b0, 16'(~(1 << code))};
            default: return {1'b1, 16'h0000};
        endcase
    endfunction

    typedef struct {
        logic [16:0] exp;
        int          t_acc;
        bit          clean;
    } beat_t;

    beat_t       q[$];
    int          cyc = 0;
    int          m_cnt = 0;
    int          n_acc = 0;
    int          run = 0;
    int          max_run = 0;
    int          last_out = -10;
    bit          have_hold = 0;
    logic [16:0] held;

    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (!reset) begin
            q.delete();
            m_cnt     = 0;
            have_hold = 0;
        end else begin
            check("cnt", 64'(xfer_cnt), 64'(m_cnt));
            check("cnt4", 64'(xfer_cnt4), 64'(m_cnt % 16));
            if (have_hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({out_err, out_data}), 64'(held));
            end
            have_hold = 0;
            if (!out_ready) foreach (q[i]) q[i].clean = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    b = q.pop_front();
                    check("data", 64'({out_err, out_data}), 64'(b.exp));
                    if (b.clean) check("latency", 64'(cyc - b.t_acc), 64'(STAGES));
`ifdef DECODER_PARITY_EN
                    check("par", 64'(out_par), 64'(^b.exp[15:0]));
`endif
                end
                m_cnt = (m_cnt + 1) % 65536;
                run   = (cyc == last_out + 1) ? run + 1 : 1;
                if (run > max_run) max_run = run;
                last_out = cyc;
            end
            if (out_valid && !out_ready) begin
                have_hold = 1;
                held      = {out_err, out_data};
            end
            if (in_valid && in_ready) begin
                q.push_back('{ref_decode(int'(in_code), int'(in_mode)), cyc, out_ready});
                n_acc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input int code, input int mode, input logic [15:0] ed, input logic ee);
        int n;
        in_code  = 4'(code);
        in_mode  = 2'(mode);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check("one_valid", 64'(out_valid), 64'd1);
        check("one_data", 64'(out_data), 64'(ed));
        check("one_err", 64'(out_err), 64'(ee));
        step();
    endtask

    initial begin
        int n0;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_code = '0; in_mode = '0;
        repeat (3) step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_cnt", 64'(xfer_cnt), 64'd0);
        reset = 1'b1;
        step();

        send_one(5, 0, 16'h0020, 1'b0);
        send_one(5, 1, 16'h003F, 1'b0);
        send_one(5, 2, 16'hFFDF, 1'b0);
        send_one(0, 1, 16'h0001, 1'b0);
        send_one(15, 1, 16'hFFFF, 1'b0);
        send_one(9, 3, 16'h0000, 1'b1);
        send_one(2, 1, 16'h0007, 1'b0);
`ifdef DECODER_PARITY_EN
        check("par_m1c2", 64'(out_par), 64'd1);
`endif
        check("cnt_after_dir", 64'(xfer_cnt), 64'd7);

        // Sweep every code in every mode at full rate.
        for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 16; c++) begin
                in_code = 4'(c); in_mode = 2'(m); in_valid = 1'b1;
                step();
            end
        end
        in_valid = 1'b0;
        repeat (4) step();

        // Stall under continuous input.
        n0 = n_acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_code = 4'($urandom); in_mode = 2'($urandom);
            step();
        end
        check("stall_accepts", 64'(n_acc - n0), 64'(STAGES));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        check("stall_drained", 64'(q.size()), 64'd0);

        // Back-to-back after a clean reset.
        reset = 1'b0; step(); reset = 1'b1; step();
        max_run = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_code = 4'(i); in_mode = 2'($urandom_range(0, 2)); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        check("b2b_cnt", 64'(xfer_cnt), 64'd16);
        check("b2b_run", 64'(max_run), 64'd16);
        check("b2b_cnt4_wrap", 64'(xfer_cnt4), 64'd0);
        send_one(3, 0, 16'h0008, 1'b0);
        check("cnt4_17", 64'(xfer_cnt4), 64'd1);
        check("cnt_17", 64'(xfer_cnt), 64'd17);

        // Asynchronous reset with two beats in flight.
        in_valid = 1'b1; in_code = 4'd6; in_mode = 2'd0;
        step();
        in_code = 4'd7;
        step();
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", 64'(out_data), 64'd0);
        check("arst_err", 64'(out_err), 64'd0);
        check("arst_cnt", 64'(xfer_cnt), 64'd0);
        check("arst_cnt4", 64'(xfer_cnt4), 64'd0);
        step();
        reset = 1'b1;
        step();

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_code   = 4'($urandom);
            in_mode   = 2'($urandom);
            out_ready = ($urandom % 4) != 0;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        check("final_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
